// File: rtl/add_sub_comp_pipe.sv
// Two-stage elastic add/sub/compare unit (ADD, SUB, SLT, CMP) with signed/unsigned compare and full flags.
// Define ADD_SUB_SAT_EN to add the sat_sel input and clamp ADD/SUB results on overflow.
module add_sub_comp_pipe #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] oprand_A,
  input  logic [DATA_W-1:0] oprand_B,
  input  logic [1:0]        op_sel,
  input  logic              unsigned_sel,
  input  logic [ID_W-1:0]   in_id,
`ifdef ADD_SUB_SAT_EN
  input  logic              sat_sel,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              less,
  output logic              equal,
  output logic              carry,
  output logic              overflow,
  output logic [ID_W-1:0]   out_id
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

`ifdef ADD_SUB_SAT_EN
  function automatic logic [DATA_W-1:0] saturate(
    input logic [DATA_W-1:0] wrapped,
    input logic              sat,
    input logic              uns,
    input logic              is_sub,
    input logic              ovf,
    input logic              cy,
    input logic              sign_a
  );
    logic signed [DATA_W-1:0] smax;
    logic signed [DATA_W-1:0] smin;
    smax = {1'b0, {(DATA_W-1){1'b1}}};
    smin = {1'b1, {(DATA_W-1){1'b0}}};
    if (!sat) return wrapped;
    if (uns) begin
      if (!is_sub && cy) return {DATA_W{1'b1}};
      if (is_sub && !cy) return {DATA_W{1'b0}};
      return wrapped;
    end
    if (ovf) return sign_a ? smin : smax;
    return wrapped;
  endfunction
`endif

  logic              vld_p1, vld_p2;
  logic              s1_load, s1_adv, s2_load;

  logic              sub_c;
  logic [DATA_W-1:0] b_eff_c;
  logic [DATA_W:0]   sum_c, diff_c;

  logic [DATA_W:0]   sum_p1, diff_p1;
  logic              sa_p1, sbeff_p1, bmsb_p1, uns_p1;
  logic [1:0]        op_p1;
  logic [ID_W-1:0]   id_p1;
`ifdef ADD_SUB_SAT_EN
  logic              sat_p1;
`endif

  logic [DATA_W-1:0] result_c;
  logic              less_c, equal_c, carry_c, ovf_c, d_ovf_c;

  logic [DATA_W-1:0] result_p2;
  logic              less_p2, equal_p2, carry_p2, ovf_p2;
  logic [ID_W-1:0]   id_p2;

  // Stage 2 refills whenever it is empty or draining, so a full pipe still accepts on out_ready.
  assign s2_load  = ~vld_p2 | out_ready;
  assign s1_adv   = vld_p1 & s2_load;
  assign in_ready = ~vld_p1 | ~vld_p2 | out_ready;
  assign s1_load  = in_valid & in_ready;

  // Stage 1: operand add/sub plus a dedicated A-B so compares never depend on the ADD sum.
  assign sub_c   = (op_sel != OP_ADD);
  assign b_eff_c = oprand_B ^ {DATA_W{sub_c}};
  assign sum_c   = {1'b0, oprand_A} + {1'b0, b_eff_c} + {{DATA_W{1'b0}}, sub_c};
  assign diff_c  = {1'b0, oprand_A} + {1'b0, ~oprand_B} + {{DATA_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (s1_load) vld_p1 <= 1'b1;
    else if (s1_adv)  vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      sum_p1   <= sum_c;
      diff_p1  <= diff_c;
      sa_p1    <= oprand_A[DATA_W-1];
      sbeff_p1 <= b_eff_c[DATA_W-1];
      bmsb_p1  <= oprand_B[DATA_W-1];
      uns_p1   <= unsigned_sel;
      op_p1    <= op_sel;
      id_p1    <= in_id;
`ifdef ADD_SUB_SAT_EN
      sat_p1   <= sat_sel;
`endif
    end
  end

  // Stage 2: flags and per-op result from the registered sums.
  always_comb begin
    ovf_c   = (sa_p1 == sbeff_p1) & (sum_p1[DATA_W-1] != sa_p1);
    d_ovf_c = (sa_p1 == ~bmsb_p1) & (diff_p1[DATA_W-1] != sa_p1);
    carry_c = sum_p1[DATA_W];
    equal_c = (diff_p1[DATA_W-1:0] == {DATA_W{1'b0}});
    less_c  = uns_p1 ? ~diff_p1[DATA_W] : (diff_p1[DATA_W-1] ^ d_ovf_c);
    result_c = {DATA_W{1'b0}};
    case (op_p1)
      OP_ADD, OP_SUB: begin
`ifdef ADD_SUB_SAT_EN
        result_c = saturate(sum_p1[DATA_W-1:0], sat_p1, uns_p1, (op_p1 == OP_SUB),
                            ovf_c, carry_c, sa_p1);
`else
        result_c = sum_p1[DATA_W-1:0];
`endif
      end
      OP_SLT:  result_c = {{(DATA_W-1){1'b0}}, less_c};
      OP_CMP:  result_c = {DATA_W{1'b0}};
      default: result_c = {DATA_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= {DATA_W{1'b0}};
      less_p2   <= 1'b0;
      equal_p2  <= 1'b0;
      carry_p2  <= 1'b0;
      ovf_p2    <= 1'b0;
      id_p2     <= {ID_W{1'b0}};
    end else begin
      if (s2_load) vld_p2 <= vld_p1;
      if (s1_adv) begin
        result_p2 <= result_c;
        less_p2   <= less_c;
        equal_p2  <= equal_c;
        carry_p2  <= carry_c;
        ovf_p2    <= ovf_c;
        id_p2     <= id_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign less      = less_p2;
  assign equal     = equal_p2;
  assign carry     = carry_p2;
  assign overflow  = ovf_p2;
  assign out_id    = id_p2;

endmodule

// File: tb/tb_add_sub_comp_pipe.sv
// Directed and exhaustive check of add_sub_comp_pipe at DATA_W=4 against a small integer model.
module tb_add_sub_comp_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] oprand_A, oprand_B;
  logic [1:0] op_sel;
  logic       unsigned_sel;
  logic [3:0] in_id;
`ifdef ADD_SUB_SAT_EN
  logic       sat_sel;
`endif
  logic       out_valid, out_ready;
  logic [3:0] result;
  logic       less, equal, carry, overflow;
  logic [3:0] out_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  add_sub_comp_pipe #(.DATA_W(4), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .oprand_A(oprand_A), .oprand_B(oprand_B),
    .op_sel(op_sel), .unsigned_sel(unsigned_sel), .in_id(in_id),
`ifdef ADD_SUB_SAT_EN
    .sat_sel(sat_sel),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .less(less), .equal(equal), .carry(carry),
    .overflow(overflow), .out_id(out_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input int op, input int a, input int b,
                                        input int uns, input int id);
    int sa, sb, r, s;
    logic l, e, c, o;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    e = (a == b);
    l = (uns != 0) ? (a < b) : (sa < sb);
    if (op == 0) begin
      s = sa + sb; r = (a + b) % 16; c = ((a + b) >= 16);
    end else begin
      s = sa - sb; r = (a - b + 16) % 16; c = (a >= b);
    end
    o = (s > 7) || (s < -8);
    if (op == 2) r = l ? 1 : 0;
    else if (op == 3) r = 0;
    return {4'(id), 4'(r), l, e, c, o};
  endfunction

  task automatic apply(input logic v, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic uns, input logic [3:0] id);
    in_valid = v; op_sel = op; oprand_A = a; oprand_B = b; unsigned_sel = uns; in_id = id;
  endtask

  // Called at a negedge with an empty pipeline; returns at a negedge with it empty again.
  task automatic directed(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic uns, input logic [3:0] r,
                          input logic [3:0] flags);
    out_ready = 1'b1;
    apply(1'b1, op, a, b, uns, 4'hA);
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(r));
    check({tag, "_flags"}, 32'({less, equal, carry, overflow}), 32'(flags));
    check({tag, "_id"}, 32'(out_id), 32'hA);
    @(negedge clk);
  endtask

  logic [11:0] q[$];
  logic [11:0] exp_v;

  initial begin
    int sent, cyc;
    rst = 1'b1; out_ready = 1'b0;
    apply(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0);
`ifdef ADD_SUB_SAT_EN
    sat_sel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_out", 32'({result, less, equal, carry, overflow, out_id}), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // flags packed as {less, equal, carry, overflow}
    directed("add_ovf",  2'b00, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0001);
    directed("add_lt",   2'b00, 4'b0011, 4'b0101, 1'b0, 4'b1000, 4'b1001);
    directed("sub_s",    2'b01, 4'b1000, 4'b0001, 1'b0, 4'b0111, 4'b1011);
    directed("sub_u",    2'b01, 4'b1000, 4'b0001, 1'b1, 4'b0111, 4'b0011);
    directed("slt_s",    2'b10, 4'b1111, 4'b0001, 1'b0, 4'b0001, 4'b1010);
    directed("slt_u",    2'b10, 4'b1111, 4'b0001, 1'b1, 4'b0000, 4'b0010);
    directed("cmp_eq",   2'b11, 4'b0101, 4'b0101, 1'b0, 4'b0000, 4'b0110);
`ifdef ADD_SUB_SAT_EN
    sat_sel = 1'b1;
    directed("sat_add",  2'b00, 4'b0111, 4'b0001, 1'b0, 4'b0111, 4'b0001);
    sat_sel = 1'b0;
`endif

    // Back-pressure: ids 0..3 (A=id, B=1, ADD), consumer stalled for 5 cycles
    out_ready = 1'b0;
    apply(1'b1, 2'b00, 4'd0, 4'd1, 1'b0, 4'd0);
    #1 check("bp_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    apply(1'b1, 2'b00, 4'd1, 4'd1, 1'b0, 4'd1);
    #1 check("bp_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    apply(1'b1, 2'b00, 4'd2, 4'd1, 1'b0, 4'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_full", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_valid, out_id, result}), 32'({1'b1, 4'd0, 4'd1}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) apply(1'b1, 2'b00, 4'd3, 4'd1, 1'b0, 4'd3);
      if (k == 2) in_valid = 1'b0;
      #1;
      if (k < 2) check("bp_acc", 32'(in_ready), 32'd1);
      check("bp_drain", 32'({out_valid, out_id, result}), 32'({1'b1, 4'(k), 4'(k + 1)}));
      @(negedge clk);
    end
    #1 check("bp_empty", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    apply(1'b1, 2'b00, 4'd7, 4'd1, 1'b0, 4'd5);
    @(negedge clk);
    apply(1'b1, 2'b00, 4'd3, 4'd5, 1'b0, 4'd6);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("mid_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_vld", 32'(out_valid), 32'd0);
    check("mid_out", 32'({result, less, equal, carry, overflow, out_id}), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("mid_stale", 32'(out_valid), 32'd0);
    end
    @(negedge clk);

    // Exhaustive operands x ops x signedness with random consumer stalls
    sent = 0; cyc = 0;
    while ((sent < 2048 || q.size() != 0) && cyc < 20000) begin
      if (sent < 2048)
        apply(1'b1, 2'((sent >> 8) & 3), 4'(sent & 15), 4'((sent >> 4) & 15),
              1'((sent >> 10) & 1), 4'(sent));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("exh_dup", 32'd1, 32'd0);
        else begin
          exp_v = q.pop_front();
          check("exh", 32'({out_id, result, less, equal, carry, overflow}), 32'(exp_v));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model((sent >> 8) & 3, sent & 15, (sent >> 4) & 15, (sent >> 10) & 1, sent & 15));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    check("exh_sent", 32'(sent), 32'd2048);
    check("exh_lost", 32'(q.size()), 32'd0);
    #1 check("exh_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
